// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader/arbiter slice.
package imem_pkg;

    typedef enum logic [0:0] {
        LOAD = 1'b0,
        RUN  = 1'b1
    } imem_state_e;

    localparam int IMEM_ADDR_W   = 10;
    localparam int IMEM_RESET_PC = 0;

endpackage : imem_pkg

// File: rtl/imem_starve_ctr.sv
// Saturating wait counter: counts cycles a request waits, clears on demand,
// and flags when the wait has reached the limit.
module imem_starve_ctr #(
    parameter int LIM = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic at_lim_o
);

    localparam int W = (LIM < 1) ? 1 : $clog2(LIM + 1);
    localparam logic [W-1:0] LIM_V = W'(LIM);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LIM_V)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_lim_o = (cnt_q == LIM_V);

endmodule : imem_starve_ctr

// File: rtl/imem_loader_arb.sv
// Boot-loads instruction memory from the loader stream, then arbitrates the
// shared byte port between fetch and loader patches. Optional boot-image
// checksum enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader_arb
    import imem_pkg::*;
#(
    parameter int                   ADDR_W     = IMEM_ADDR_W,
    parameter int                   LOAD_BYTES = 1024,
    parameter logic [ADDR_W-1:0]    BASE_ADDR  = ADDR_W'(IMEM_RESET_PC),
    parameter int                   STARVE_LIM = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ld_valid_i,
    input  logic [7:0]        ld_data_i,
    input  logic              ld_last_i,
    output logic              ld_ready_o,
    input  logic              fetch_req_i,
    input  logic [ADDR_W-1:0] fetch_addr_i,
    output logic              fetch_gnt_o,
    output logic              stall_f_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [7:0]        mem_wdata_o,
    output logic              boot_done_o,
    output logic [ADDR_W-1:0] ld_ptr_o
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    input  logic [7:0]        ld_csum_i,
    output logic              csum_ok_o,
    output logic              csum_err_o
`endif
);

    localparam int CNT_W = $clog2(LOAD_BYTES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LOAD_BYTES - 1);

    imem_state_e       state_q, state_d;
    logic [ADDR_W-1:0] ld_ptr_q, ld_ptr_d;
    logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic              ld_grant;
    logic              boot_end;
    logic              starve_at_lim;

    imem_starve_ctr #(
        .LIM (STARVE_LIM)
    ) u_starve (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (~ld_valid_i | ld_grant | (state_q != RUN)),
        .inc_i    (ld_valid_i & ~ld_grant),
        .at_lim_o (starve_at_lim)
    );

    // Reset forces the safe output set: nothing granted, fetch stalled.
    always_comb begin
        state_d     = state_q;
        ld_ptr_d    = ld_ptr_q;
        byte_cnt_d  = byte_cnt_q;
        ld_grant    = 1'b0;
        boot_end    = 1'b0;
        ld_ready_o  = 1'b0;
        fetch_gnt_o = 1'b0;
        stall_f_o   = 1'b1;
        mem_we_o    = 1'b0;
        mem_addr_o  = fetch_addr_i;
        if (!rst_i) begin
            unique case (state_q)
                LOAD: begin
                    ld_ready_o = 1'b1;
                    if (ld_valid_i) begin
                        ld_grant   = 1'b1;
                        mem_we_o   = 1'b1;
                        mem_addr_o = ld_ptr_q;
                        byte_cnt_d = byte_cnt_q + CNT_W'(1);
                        if (ld_last_i || (byte_cnt_q == LAST_CNT)) begin
                            boot_end = 1'b1;
                            state_d  = RUN;
                        end
                    end
                end
                RUN: begin
                    ld_grant = ld_valid_i & (~fetch_req_i | starve_at_lim);
                    if (ld_grant) begin
                        ld_ready_o = 1'b1;
                        mem_we_o   = 1'b1;
                        mem_addr_o = ld_ptr_q;
                        stall_f_o  = fetch_req_i;
                    end else begin
                        fetch_gnt_o = fetch_req_i;
                        stall_f_o   = 1'b0;
                    end
                end
                default: ;
            endcase
            if (ld_grant) begin
                ld_ptr_d = ld_ptr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= LOAD;
            ld_ptr_q   <= BASE_ADDR;
            byte_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ld_ptr_q   <= ld_ptr_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    assign mem_wdata_o = ld_data_i;
    assign boot_done_o = (state_q == RUN);
    assign ld_ptr_o    = ld_ptr_q;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;
    logic       csum_ok_q, csum_ok_d;
    logic       csum_err_q, csum_err_d;

    // Only boot bytes feed the XOR; the verdict latches with the final byte.
    always_comb begin
        csum_d     = csum_q;
        csum_ok_d  = csum_ok_q;
        csum_err_d = csum_err_q;
        if ((state_q == LOAD) && ld_grant) begin
            csum_d = csum_q ^ ld_data_i;
            if (boot_end) begin
                csum_ok_d  = ((csum_q ^ ld_data_i) == ld_csum_i);
                csum_err_d = ((csum_q ^ ld_data_i) != ld_csum_i);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            csum_q     <= '0;
            csum_ok_q  <= 1'b0;
            csum_err_q <= 1'b0;
        end else begin
            csum_q     <= csum_d;
            csum_ok_q  <= csum_ok_d;
            csum_err_q <= csum_err_d;
        end
    end

    assign csum_ok_o  = csum_ok_q;
    assign csum_err_o = csum_err_q;
`endif

endmodule : imem_loader_arb

// File: tb/tb_imem_loader_arb.sv
// Directed self-checking bench for imem_loader_arb (LOAD_BYTES=4, STARVE_LIM=4).
module tb_imem_loader_arb;

    localparam int ADDR_W = 10;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              ld_valid_i;
    logic [7:0]        ld_data_i;
    logic              ld_last_i;
    logic              ld_ready_o;
    logic              fetch_req_i;
    logic [ADDR_W-1:0] fetch_addr_i;
    logic              fetch_gnt_o;
    logic              stall_f_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_we_o;
    logic [7:0]        mem_wdata_o;
    logic              boot_done_o;
    logic [ADDR_W-1:0] ld_ptr_o;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        ld_csum_i;
    logic              csum_ok_o;
    logic              csum_err_o;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    imem_loader_arb #(
        .ADDR_W     (ADDR_W),
        .LOAD_BYTES (4),
        .BASE_ADDR  ('0),
        .STARVE_LIM (4)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .ld_valid_i   (ld_valid_i),
        .ld_data_i    (ld_data_i),
        .ld_last_i    (ld_last_i),
        .ld_ready_o   (ld_ready_o),
        .fetch_req_i  (fetch_req_i),
        .fetch_addr_i (fetch_addr_i),
        .fetch_gnt_o  (fetch_gnt_o),
        .stall_f_o    (stall_f_o),
        .mem_addr_o   (mem_addr_o),
        .mem_we_o     (mem_we_o),
        .mem_wdata_o  (mem_wdata_o),
        .boot_done_o  (boot_done_o),
        .ld_ptr_o     (ld_ptr_o)
`ifdef IMEM_LOADER_CHECKSUM_EN
        ,
        .ld_csum_i    (ld_csum_i),
        .csum_ok_o    (csum_ok_o),
        .csum_err_o   (csum_err_o)
`endif
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i       = 1'b1;
        ld_valid_i  = 1'b0;
        ld_last_i   = 1'b0;
        fetch_req_i = 1'b0;
        step();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i        = 1'b1;
        ld_valid_i   = 1'b1;
        ld_data_i    = 8'h5A;
        ld_last_i    = 1'b1;
        fetch_req_i  = 1'b1;
        fetch_addr_i = 10'h155;
        #1;
        checks++; if (ld_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ld_ready got=%b exp=0", ld_ready_o); end
        checks++; if (mem_we_o !== 1'b0) begin errors++; $display("FAIL rst_mem_we got=%b exp=0", mem_we_o); end
        checks++; if (fetch_gnt_o !== 1'b0) begin errors++; $display("FAIL rst_fetch_gnt got=%b exp=0", fetch_gnt_o); end
        checks++; if (stall_f_o !== 1'b1) begin errors++; $display("FAIL rst_stall got=%b exp=1", stall_f_o); end
        step();
        step();
        checks++; if (ld_ptr_o !== 10'd0) begin errors++; $display("FAIL rst_ld_ptr got=%0d exp=0", ld_ptr_o); end
        checks++; if (boot_done_o !== 1'b0) begin errors++; $display("FAIL rst_boot_done got=%b exp=0", boot_done_o); end
        ld_valid_i  = 1'b0;
        ld_last_i   = 1'b0;
        fetch_req_i = 1'b0;
        rst_i       = 1'b0;
    endtask

    task automatic test_boot();
        logic [7:0] bytes [3];
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
        do_reset();
        fetch_addr_i = 10'h155;
        for (int i = 0; i < 3; i++) begin
            ld_valid_i  = 1'b1;
            ld_data_i   = bytes[i];
            ld_last_i   = (i == 2);
            fetch_req_i = 1'b1;
            #1;
            checks++; if (mem_we_o !== 1'b1 || mem_addr_o !== 10'(i)) begin errors++; $display("FAIL boot_write%0d got we=%b addr=%0d exp we=1 addr=%0d", i, mem_we_o, mem_addr_o, i); end
            checks++; if (mem_wdata_o !== bytes[i] || ld_ready_o !== 1'b1) begin errors++; $display("FAIL boot_data%0d got=%h rdy=%b exp=%h rdy=1", i, mem_wdata_o, ld_ready_o, bytes[i]); end
            checks++; if (stall_f_o !== 1'b1 || fetch_gnt_o !== 1'b0) begin errors++; $display("FAIL boot_stall%0d got stall=%b gnt=%b exp stall=1 gnt=0", i, stall_f_o, fetch_gnt_o); end
            checks++; if (boot_done_o !== 1'b0) begin errors++; $display("FAIL boot_done_early%0d got=%b exp=0", i, boot_done_o); end
            step();
        end
        ld_valid_i = 1'b0;
        ld_last_i  = 1'b0;
        #1;
        checks++; if (boot_done_o !== 1'b1) begin errors++; $display("FAIL boot_done got=%b exp=1", boot_done_o); end
        checks++; if (fetch_gnt_o !== 1'b1 || stall_f_o !== 1'b0 || mem_addr_o !== 10'h155 || mem_we_o !== 1'b0) begin errors++; $display("FAIL first_fetch got gnt=%b stall=%b addr=%h we=%b exp 1 0 155 0", fetch_gnt_o, stall_f_o, mem_addr_o, mem_we_o); end
        checks++; if (ld_ptr_o !== 10'd3) begin errors++; $display("FAIL boot_ld_ptr got=%0d exp=3", ld_ptr_o); end
        fetch_req_i = 1'b0;
        step();
    endtask

    task automatic test_auto_end();
        do_reset();
        fetch_req_i  = 1'b0;
        fetch_addr_i = 10'h2AA;
        for (int i = 0; i < 6; i++) begin
            ld_valid_i = 1'b1;
            ld_data_i  = 8'hC0 + 8'(i);
            ld_last_i  = 1'b0;
            #1;
            checks++; if (boot_done_o !== (i >= 4)) begin errors++; $display("FAIL auto_boot_done%0d got=%b exp=%b", i, boot_done_o, (i >= 4)); end
            checks++; if (mem_we_o !== 1'b1 || mem_addr_o !== 10'(i) || ld_ready_o !== 1'b1) begin errors++; $display("FAIL auto_write%0d got we=%b addr=%0d rdy=%b exp 1 %0d 1", i, mem_we_o, mem_addr_o, ld_ready_o, i); end
            checks++; if (stall_f_o !== (i < 4)) begin errors++; $display("FAIL auto_stall%0d got=%b exp=%b", i, stall_f_o, (i < 4)); end
            step();
        end
        ld_valid_i = 1'b0;
        #1;
        checks++; if (ld_ptr_o !== 10'd6) begin errors++; $display("FAIL auto_ld_ptr got=%0d exp=6", ld_ptr_o); end
    endtask

    task automatic test_starvation();
        // Continues in RUN from test_auto_end with ld_ptr = 6.
        fetch_req_i  = 1'b1;
        fetch_addr_i = 10'h0F0;
        ld_valid_i   = 1'b0;
        step();
        ld_valid_i = 1'b1;
        ld_data_i  = 8'h99;
        for (int k = 0; k <= 4; k++) begin
            #1;
            if (k < 4) begin
                checks++; if (ld_ready_o !== 1'b0 || fetch_gnt_o !== 1'b1 || stall_f_o !== 1'b0 || mem_we_o !== 1'b0 || mem_addr_o !== 10'h0F0) begin errors++; $display("FAIL starve_wait%0d got rdy=%b gnt=%b stall=%b we=%b addr=%h exp 0 1 0 0 0f0", k, ld_ready_o, fetch_gnt_o, stall_f_o, mem_we_o, mem_addr_o); end
            end else begin
                checks++; if (ld_ready_o !== 1'b1 || fetch_gnt_o !== 1'b0 || stall_f_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 10'd6) begin errors++; $display("FAIL starve_grant got rdy=%b gnt=%b stall=%b we=%b addr=%0d exp 1 0 1 1 6", ld_ready_o, fetch_gnt_o, stall_f_o, mem_we_o, mem_addr_o); end
            end
            step();
        end
        ld_valid_i = 1'b0;
        #1;
        checks++; if (ld_ptr_o !== 10'd7) begin errors++; $display("FAIL starve_ld_ptr got=%0d exp=7", ld_ptr_o); end
        checks++; if (fetch_gnt_o !== 1'b1 || stall_f_o !== 1'b0) begin errors++; $display("FAIL starve_after got gnt=%b stall=%b exp 1 0", fetch_gnt_o, stall_f_o); end
        step();
    endtask

    task automatic test_idle_fetch();
        fetch_req_i = 1'b0;
        ld_valid_i  = 1'b1;
        ld_data_i   = 8'hA5;
        #1;
        checks++; if (ld_ready_o !== 1'b1 || fetch_gnt_o !== 1'b0 || stall_f_o !== 1'b0) begin errors++; $display("FAIL idle_handshake got rdy=%b gnt=%b stall=%b exp 1 0 0", ld_ready_o, fetch_gnt_o, stall_f_o); end
        checks++; if (mem_we_o !== 1'b1 || mem_addr_o !== 10'd7 || mem_wdata_o !== 8'hA5) begin errors++; $display("FAIL idle_write got we=%b addr=%0d data=%h exp 1 7 a5", mem_we_o, mem_addr_o, mem_wdata_o); end
        step();
        ld_valid_i = 1'b0;
        #1;
        checks++; if (ld_ptr_o !== 10'd8) begin errors++; $display("FAIL idle_ld_ptr got=%0d exp=8", ld_ptr_o); end
        checks++; if (mem_we_o !== 1'b0 || fetch_gnt_o !== 1'b0 || stall_f_o !== 1'b0) begin errors++; $display("FAIL idle_quiet got we=%b gnt=%b stall=%b exp 0 0 0", mem_we_o, fetch_gnt_o, stall_f_o); end
        step();
    endtask

    task automatic test_mid_load_reset();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            ld_valid_i = 1'b1;
            ld_data_i  = 8'h40 + 8'(i);
            ld_last_i  = 1'b0;
            step();
        end
        ld_valid_i = 1'b0;
        #1;
        checks++; if (ld_ptr_o !== 10'd2) begin errors++; $display("FAIL mid_pre_ptr got=%0d exp=2", ld_ptr_o); end
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        #1;
        checks++; if (ld_ptr_o !== 10'd0 || boot_done_o !== 1'b0) begin errors++; $display("FAIL mid_reset got ptr=%0d done=%b exp 0 0", ld_ptr_o, boot_done_o); end
        for (int i = 0; i < 3; i++) begin
            ld_valid_i  = 1'b1;
            ld_data_i   = 8'h50 + 8'(i);
            ld_last_i   = (i == 2);
            fetch_req_i = 1'b1;
            #1;
            checks++; if (mem_we_o !== 1'b1 || mem_addr_o !== 10'(i) || stall_f_o !== 1'b1 || boot_done_o !== 1'b0) begin errors++; $display("FAIL mid_reload%0d got we=%b addr=%0d stall=%b done=%b exp 1 %0d 1 0", i, mem_we_o, mem_addr_o, stall_f_o, boot_done_o, i); end
            step();
        end
        ld_valid_i  = 1'b0;
        ld_last_i   = 1'b0;
        fetch_req_i = 1'b0;
        #1;
        checks++; if (boot_done_o !== 1'b1) begin errors++; $display("FAIL mid_reload_done got=%b exp=1", boot_done_o); end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] sums [2];
        sums[0] = 8'hFF; sums[1] = 8'h00;
        for (int r = 0; r < 2; r++) begin
            do_reset();
            ld_csum_i = sums[r];
            ld_valid_i = 1'b1; ld_data_i = 8'h0F; ld_last_i = 1'b0;
            step();
            ld_data_i = 8'hF0; ld_last_i = 1'b1;
            #1;
            checks++; if (csum_ok_o !== 1'b0 || csum_err_o !== 1'b0) begin errors++; $display("FAIL csum_early%0d got ok=%b err=%b exp 0 0", r, csum_ok_o, csum_err_o); end
            step();
            ld_valid_i = 1'b0; ld_last_i = 1'b0;
            #1;
            checks++; if (csum_ok_o !== (r == 0) || csum_err_o !== (r == 1)) begin errors++; $display("FAIL csum_result%0d got ok=%b err=%b exp %b %b", r, csum_ok_o, csum_err_o, (r == 0), (r == 1)); end
            ld_valid_i = 1'b1; ld_data_i = 8'h00;
            step();
            ld_valid_i = 1'b0;
            #1;
            checks++; if (csum_ok_o !== (r == 0) || csum_err_o !== (r == 1)) begin errors++; $display("FAIL csum_patch%0d got ok=%b err=%b exp %b %b", r, csum_ok_o, csum_err_o, (r == 0), (r == 1)); end
        end
    endtask
`endif

    initial begin
        ld_data_i    = 8'h00;
        fetch_addr_i = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        ld_csum_i    = 8'h00;
`endif
        test_reset();
        test_boot();
        test_auto_end();
        test_starvation();
        test_idle_fetch();
        test_mid_load_reset();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_imem_loader_arb
